// File: rtl/act_mem_loader_pkg.sv
// Shared definitions for the activation/weight memory loaders: FSM encoding and local port index.
package act_mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSIGN,
    S_SETTLE,
    S_WRITE,
    S_DRAIN,
    S_UNASSIGN,
    S_DONE
  } state_t;

  // The host-side port sits just past the kernel ports.
  function automatic int local_port(input int num_kernels);
    return num_kernels;
  endfunction

endpackage

// File: rtl/act_mem_loader.sv
// Host-side loader: assigns the local port to an activation memory, streams a burst into it, unassigns.
module act_mem_loader
  import act_mem_loader_pkg::*;
#(
  parameter int GROUP_SIZE           = 4,
  parameter int DATA_WIDTH           = 8,
  parameter int NUM_KERNELS          = 2,
  parameter int LOG_NUM_KERNELS      = 1,
  parameter int LOG_NUM_ACT_MEMORIES = 1,
  parameter int LOG_MAX_ADDRESS      = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [LOG_NUM_ACT_MEMORIES-1:0]      mem_id,
  input  logic [LOG_MAX_ADDRESS-1:0]           base_addr,
  input  logic [LOG_MAX_ADDRESS:0]             num_words,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]     s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 cmd_act_assign,
  output logic                                 cmd_act_unassign,
  output logic [LOG_NUM_KERNELS:0]             cmd_act_read_port,
  output logic [LOG_NUM_KERNELS:0]             cmd_act_write_port,
  output logic [LOG_NUM_ACT_MEMORIES-1:0]      cmd_act_memory,
  output logic                                 act_write,
  output logic [LOG_MAX_ADDRESS-1:0]           act_write_addr,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0]     act_write_data
);

  localparam int CW = LOG_MAX_ADDRESS + 1;
  localparam int PW = LOG_NUM_KERNELS + 1;
  localparam logic [PW-1:0] PORT = PW'(local_port(NUM_KERNELS));

  state_t                            state, state_n;
  logic [LOG_NUM_ACT_MEMORIES-1:0]   mem_q, mem_n;
  logic [LOG_MAX_ADDRESS-1:0]        base_q, base_n;
  logic [CW-1:0]                     num_q, num_n, cnt_q, cnt_n;
  logic                              beat, cmd_n;

  assign beat  = (state == S_WRITE) && s_valid && s_ready;
  assign cmd_n = (state_n == S_ASSIGN) || (state_n == S_UNASSIGN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      mem_q  <= '0;
      base_q <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      mem_q  <= mem_n;
      base_q <= base_n;
      num_q  <= num_n;
      cnt_q  <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    mem_n   = mem_q;
    base_n  = base_q;
    num_n   = num_q;
    cnt_n   = beat ? cnt_q + 1'b1 : cnt_q;
    case (state)
      S_IDLE: if (start) begin
        mem_n   = mem_id;
        base_n  = base_addr;
        num_n   = num_words;
        cnt_n   = '0;
        // Empty bursts skip the memory commands but still show busy for one cycle.
        state_n = (num_words == '0) ? S_DRAIN : S_ASSIGN;
      end
      S_ASSIGN:   state_n = S_SETTLE;
      S_SETTLE:   state_n = S_WRITE;
      // Stay one cycle past the last beat so its write lands before DRAIN.
      S_WRITE:    if (cnt_q == num_q) state_n = S_DRAIN;
      S_DRAIN:    state_n = (num_q == '0) ? S_DONE : S_UNASSIGN;
      S_UNASSIGN: state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so every port is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready            <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      cmd_act_assign     <= 1'b0;
      cmd_act_unassign   <= 1'b0;
      cmd_act_read_port  <= '0;
      cmd_act_write_port <= '0;
      cmd_act_memory     <= '0;
      act_write          <= 1'b0;
      act_write_addr     <= '0;
      act_write_data     <= '0;
    end else begin
      s_ready            <= (state_n == S_WRITE) && (cnt_n < num_n);
      busy               <= (state_n != S_IDLE) && (state_n != S_DONE);
      done               <= (state_n == S_DONE);
      cmd_act_assign     <= (state_n == S_ASSIGN);
      cmd_act_unassign   <= (state_n == S_UNASSIGN);
      cmd_act_read_port  <= cmd_n ? PORT : '0;
      cmd_act_write_port <= cmd_n ? PORT : '0;
      cmd_act_memory     <= cmd_n ? mem_n : '0;
      act_write          <= beat;
      if (beat) begin
        act_write_addr <= base_q + cnt_q[LOG_MAX_ADDRESS-1:0];
        act_write_data <= s_data;
      end
    end
  end

endmodule
